// File: rtl/foo_stream.sv
// Streaming res = ((a-b)*(3c+1) - 4d) / 2^SHIFT with per-transaction rounding and
// overflow modes, four registered stages and bubble-free valid/ready backpressure.
module foo_stream #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1,
    parameter int TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] a_in,
    input  logic signed [WIDTH-1:0] b_in,
    input  logic signed [WIDTH-1:0] c_in,
    input  logic signed [WIDTH-1:0] d_in,
    input  logic [TAG_W-1:0]        tag_in,
    input  logic                    rnd_tz_in,
    input  logic                    sat_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] res,
    output logic [TAG_W-1:0]        tag_out,
    output logic                    ovf,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int STAGES = 4;
    localparam int DW     = WIDTH + 1;
    localparam int MW     = WIDTH + 2;
    localparam int PW     = 2 * WIDTH + 3;
    localparam int VW     = 2 * WIDTH + 4;

    localparam logic [VW-1:0]        LOW_MASK = (VW'(1) << SHIFT) - VW'(1);
    localparam logic signed [VW-1:0] R_ONE    = VW'(1);
    localparam logic signed [VW-1:0] R_ZERO   = '0;
    localparam logic signed [VW-1:0] R_MAX    = {{(VW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [VW-1:0] R_MIN    = {{(VW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             rnd_tz;
        logic             sat;
    } ctl_t;

    logic [STAGES-1:0] vld_pipe;
    logic adv0, adv1, adv2, adv3;

    // Each stage may load whenever the stage ahead of it is empty or moving.
    assign adv3      = !vld_pipe[3] || out_ready;
    assign adv2      = !vld_pipe[2] || adv3;
    assign adv1      = !vld_pipe[1] || adv2;
    assign adv0      = !vld_pipe[0] || adv1;
    assign in_ready  = adv0;
    assign out_valid = vld_pipe[3];

    logic signed [WIDTH-1:0] a0, b0, c0, d0;
    ctl_t                    ctl0, ctl1, ctl2;
    logic signed [DW-1:0]    diff1;
    logic signed [MW-1:0]    m1, q1, q2;
    logic signed [PW-1:0]    p2;

    always_ff @(posedge clk) begin
        if (adv0 && in_valid) begin
            a0   <= a_in;
            b0   <= b_in;
            c0   <= c_in;
            d0   <= d_in;
            ctl0 <= {tag_in, rnd_tz_in, sat_in};
        end
        if (adv1 && vld_pipe[0]) begin
            diff1 <= DW'(a0) - DW'(b0);
            m1    <= (MW'(c0) <<< 1) + MW'(c0) + MW'(1);
            q1    <= MW'(d0) <<< 2;
            ctl1  <= ctl0;
        end
        if (adv2 && vld_pipe[1]) begin
            p2   <= PW'(diff1) * PW'(m1);
            q2   <= q1;
            ctl2 <= ctl1;
        end
    end

    logic signed [VW-1:0]    v3, r3;
    logic                    rnd_up, ovf_nx;
    logic signed [WIDTH-1:0] res_nx;

    // Toward-zero differs from floor only for negative values with dropped bits.
    always_comb begin
        v3     = VW'(p2) - VW'(q2);
        rnd_up = ctl2.rnd_tz && v3[VW-1] && ((v3 & LOW_MASK) != '0);
        r3     = (v3 >>> SHIFT) + (rnd_up ? R_ONE : R_ZERO);
        ovf_nx = (r3 > R_MAX) || (r3 < R_MIN);
        res_nx = r3[WIDTH-1:0];
        if (ctl2.sat && ovf_nx)
            res_nx = r3[VW-1] ? R_MIN[WIDTH-1:0] : R_MAX[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            res      <= '0;
            tag_out  <= '0;
            ovf      <= 1'b0;
        end else begin
            if (adv0) vld_pipe[0] <= in_valid;
            if (adv1) vld_pipe[1] <= vld_pipe[0];
            if (adv2) vld_pipe[2] <= vld_pipe[1];
            if (adv3) begin
                vld_pipe[3] <= vld_pipe[2];
                if (vld_pipe[2]) begin
                    res     <= res_nx;
                    ovf     <= ovf_nx;
                    tag_out <= ctl2.tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_foo_stream.sv
// Bench for foo_stream: a 32-bit and an 8-bit instance share stimulus; results are
// checked against vector tables and an exact wide-integer reference model.
module tb_foo_stream;

    localparam int SHIFT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic signed [31:0] a, b, c, d;
    logic [3:0]         tag;
    logic               rnd_tz, sat, in_valid, out_ready;
    logic               in_ready32, in_ready8, out_valid32, out_valid8, ovf32, ovf8;
    logic signed [31:0] res32;
    logic signed [7:0]  res8;
    logic [3:0]         tag32, tag8;

    foo_stream #(.WIDTH(32), .SHIFT(SHIFT), .TAG_W(4)) u_dut32 (
        .clk(clk), .rst(rst), .a_in(a), .b_in(b), .c_in(c), .d_in(d),
        .tag_in(tag), .rnd_tz_in(rnd_tz), .sat_in(sat), .in_valid(in_valid),
        .in_ready(in_ready32), .res(res32), .tag_out(tag32), .ovf(ovf32),
        .out_valid(out_valid32), .out_ready(out_ready)
    );

    foo_stream #(.WIDTH(8), .SHIFT(SHIFT), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .a_in(a[7:0]), .b_in(b[7:0]), .c_in(c[7:0]), .d_in(d[7:0]),
        .tag_in(tag), .rnd_tz_in(rnd_tz), .sat_in(sat), .in_valid(in_valid),
        .in_ready(in_ready8), .res(res8), .tag_out(tag8), .ovf(ovf8),
        .out_valid(out_valid8), .out_ready(out_ready)
    );

    typedef struct {
        int a, b, c, d, tz, sat, r32, o32, r8, o8;
    } vec_t;

    typedef struct {
        logic signed [127:0] r32, r8;
        logic                o32, o8;
        logic [3:0]          tag;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_pop = 0;

    task automatic chk(input string nm, input logic signed [127:0] act,
                       input logic signed [127:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, want);
        end
    endtask

    // Exact value by integer division, then range check and wrap/clamp.
    function automatic void ref_calc(input int w, input logic signed [127:0] ra, rb, rc, rd,
                                     input logic tz, st,
                                     output logic signed [127:0] r_o, output logic ovf_o);
        logic signed [127:0] v, dv, q, mx, mn, md, md_span;
        v  = (ra - rb) * (128'sd3 * rc + 128'sd1) - 128'sd4 * rd;
        dv = 128'sd1 <<< SHIFT;
        q  = v / dv;
        if (!tz && v < 0 && (v % dv) != '0) q = q - 128'sd1;
        mx      = (128'sd1 <<< (w - 1)) - 128'sd1;
        mn      = -(128'sd1 <<< (w - 1));
        md_span = 128'sd1 <<< w;
        ovf_o   = (q > mx) || (q < mn);
        if (st && ovf_o) begin
            r_o = (q > mx) ? mx : mn;
        end else begin
            md = q & (md_span - 128'sd1);
            if (md > mx) md = md - md_span;
            r_o = md;
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            sbq.delete();
        end else begin
            if (out_valid32 && out_ready) begin
                n_pop++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_spurious: output tag %0d with no transaction pending", tag32);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_res32", res32, e.r32);
                    chk("sb_ovf32", ovf32, e.o32);
                    chk("sb_tag32", tag32, e.tag);
                    chk("sb_valid8", out_valid8, 1);
                    chk("sb_res8", res8, e.r8);
                    chk("sb_ovf8", ovf8, e.o8);
                    chk("sb_tag8", tag8, e.tag);
                end
            end
            if (in_valid && in_ready32) begin
                ref_calc(32, 128'(a), 128'(b), 128'(c), 128'(d), rnd_tz, sat, e.r32, e.o32);
                ref_calc(8, 128'($signed(a[7:0])), 128'($signed(b[7:0])),
                         128'($signed(c[7:0])), 128'($signed(d[7:0])), rnd_tz, sat, e.r8, e.o8);
                e.tag = tag;
                sbq.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t tv, input int tg);
        a      = tv.a;
        b      = tv.b;
        c      = tv.c;
        d      = tv.d;
        rnd_tz = tv.tz[0];
        sat    = tv.sat[0];
        tag    = tg[3:0];
    endtask

    function automatic logic signed [31:0] rnd_op();
        if ($urandom_range(0, 1) == 1) return $urandom;
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic rand_ops();
        a      = rnd_op();
        b      = rnd_op();
        c      = rnd_op();
        d      = rnd_op();
        rnd_tz = 1'($urandom_range(0, 1));
        sat    = 1'($urandom_range(0, 1));
        tag    = 4'($urandom_range(0, 15));
    endtask

    // Single transaction into an empty pipe: latency and table values.
    task automatic run_row(input vec_t tv, input int tg, input string nm);
        int lat;
        drive(tv, tg);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({nm, "_in_ready"}, in_ready32, 1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid32 && lat < 20) begin
            tick();
            lat++;
        end
        chk({nm, "_latency"}, lat, 4);
        chk({nm, "_res32"}, res32, tv.r32);
        chk({nm, "_ovf32"}, ovf32, tv.o32);
        chk({nm, "_res8"}, res8, tv.r8);
        chk({nm, "_ovf8"}, ovf8, tv.o8);
        chk({nm, "_tag"}, tag32, tg);
        tick();
    endtask

    vec_t tbl[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int idx, next_tag, first_c, last_c, sent, pops0;
        logic signed [31:0] hold_res;
        logic [3:0] hold_tag;
        bit have_hold;

        //          a             b             c             d     tz sat r32          o32 r8   o8
        tbl[0]  = '{10,           3,            2,            1,    0, 0,  22,          0,  22,  0};
        tbl[1]  = '{10,           3,            2,            1,    1, 1,  22,          0,  22,  0};
        tbl[2]  = '{3,            10,           2,            1,    0, 0,  -27,         0,  -27, 0};
        tbl[3]  = '{3,            10,           2,            1,    1, 0,  -26,         0,  -26, 0};
        tbl[4]  = '{127,          -128,         127,          0,    0, 1,  48705,       0,  127, 1};
        tbl[5]  = '{127,          -128,         127,          0,    0, 0,  48705,       0,  65,  1};
        tbl[6]  = '{-128,         127,          127,          0,    0, 1,  -48705,      0,  -128, 1};
        tbl[7]  = '{-128,         127,          127,          0,    1, 0,  -48705,      0,  -65, 1};
        tbl[8]  = '{32'sh7FFFFFFF, 32'sh80000000, 32'sh7FFFFFFF, 0, 1, 1,  2147483647,  1,  1,   0};
        tbl[9]  = '{32'sh7FFFFFFF, 32'sh80000000, 32'sh7FFFFFFF, 0, 1, 0,  1073741825,  1,  1,   0};
        tbl[10] = '{0,            0,            0,            -128, 0, 1,  256,         0,  127, 1};
        tbl[11] = '{0,            1,            0,            0,    1, 0,  0,           0,  0,   0};
        tbl[12] = '{0,            1,            0,            0,    0, 0,  -1,          0,  -1,  0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0; tag = '0; rnd_tz = 1'b0; sat = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_out_valid32", out_valid32, 0);
        chk("reset_out_valid8", out_valid8, 0);
        chk("reset_res32", res32, 0);
        chk("reset_res8", res8, 0);
        chk("reset_ovf32", ovf32, 0);
        chk("reset_tag32", tag32, 0);
        chk("reset_in_ready", in_ready32, 1);

        for (int i = 0; i < 13; i++) run_row(tbl[i], i, $sformatf("row%0d", i));

        // Back-to-back with alternating rounding mode at full throughput.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(tbl[2 + (k % 2)], k);
            in_valid = 1'b1;
            chk("b2b_in_ready", in_ready32, 1);
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("b2b_valid", out_valid32, 1);
            chk("b2b_res32", res32, tbl[2 + (k % 2)].r32);
            chk("b2b_tag", tag32, k);
            tick();
        end

        // Backpressure: six tags offered while the consumer stalls.
        out_ready = 1'b0; idx = 0; have_hold = 1'b0; hold_res = '0; hold_tag = '0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            rand_ops();
            tag = idx[3:0];
            in_valid = (idx < 6);
            if (out_valid32) begin
                if (have_hold) begin
                    chk("bp_hold_res", res32, hold_res);
                    chk("bp_hold_tag", tag32, hold_tag);
                end
                hold_res = res32; hold_tag = tag32; have_hold = 1'b1;
            end
            @(negedge clk);
            if (in_valid && in_ready32) idx++;
            tick();
        end
        chk("bp_accepted", idx, 4);
        chk("bp_in_ready_low", in_ready32, 0);
        chk("bp_saw_output", have_hold, 1);
        out_ready = 1'b1; next_tag = 0; first_c = -1; last_c = -1;
        for (int cyc = 0; cyc < 20 && next_tag < 6; cyc++) begin
            rand_ops();
            tag = idx[3:0];
            in_valid = (idx < 6);
            @(negedge clk);
            if (out_valid32) begin
                chk("bp_order", tag32, next_tag);
                next_tag++;
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
            if (in_valid && in_ready32) idx++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_count", next_tag, 6);
        chk("bp_gapless", last_c - first_c, 5);
        chk("bp_all_accepted", idx, 6);

        // Reset with three transactions in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(tbl[4 + k], k + 1);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("rst_pre_valid", out_valid32, 1);
        rst = 1'b1;
        tick();
        chk("rst_out_valid32", out_valid32, 0);
        chk("rst_out_valid8", out_valid8, 0);
        chk("rst_res32", res32, 0);
        chk("rst_res8", res8, 0);
        chk("rst_ovf8", ovf8, 0);
        chk("rst_tag", tag32, 0);
        rst = 1'b0;
        run_row(tbl[0], 9, "post_rst");

        // Random traffic with random stalls against the reference model.
        sent = 0; pops0 = n_pop;
        for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
            rand_ops();
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready32) sent++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && sbq.size() != 0; cyc++) tick();
        chk("rand_sent", sent, 1000);
        chk("rand_drained", sbq.size(), 0);
        chk("rand_outputs", n_pop - pops0, 1000);
        chk("rand_idle", out_valid32, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
